// File: rtl/branch_ctrl.sv
// rtl/branch_ctrl.sv - conditional-branch strobe sequencer with taken/not-taken statistics
// Moore FSM: each state's strobes are registered so they are glitch-free on the shared bus.
module branch_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic             con_q,
  output logic             busy,
  output logic             gra,
  output logic             r_out,
  output logic             con_en,
  output logic             pc_out,
  output logic             y_in,
  output logic             c_out,
  output logic             alu_add,
  output logic             z_in,
  output logic             zlo_out,
  output logic             pc_in,
  output logic             done,
  output logic             taken,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] ntaken_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_RA, S_CON, S_PC, S_ADD, S_WB, S_FIN
  } state_t;

  typedef struct packed {
    logic busy;
    logic gra;
    logic r_out;
    logic con_en;
    logic pc_out;
    logic y_in;
    logic c_out;
    logic alu_add;
    logic z_in;
    logic zlo_out;
    logic pc_in;
    logic done;
  } strobe_t;

  state_t           state_q, state_d;
  strobe_t          strb_q, strb_d;
  logic             taken_q, taken_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] ntaken_cnt_q, ntaken_cnt_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RA;
      S_RA:    state_d = S_CON;
      S_CON:   state_d = S_PC;
      S_PC:    state_d = S_ADD;
      S_ADD:   state_d = S_WB;
      S_WB:    state_d = S_FIN;
      S_FIN:   state_d = start ? S_RA : S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Strobes are decoded from the next state so they appear in the state's own cycle.
    strb_d = '0;
    case (state_d)
      S_RA: begin
        strb_d.busy  = 1'b1;
        strb_d.gra   = 1'b1;
        strb_d.r_out = 1'b1;
      end
      S_CON: begin
        strb_d.busy   = 1'b1;
        strb_d.gra    = 1'b1;
        strb_d.r_out  = 1'b1;
        strb_d.con_en = 1'b1;
      end
      S_PC: begin
        strb_d.busy   = 1'b1;
        strb_d.pc_out = 1'b1;
        strb_d.y_in   = 1'b1;
      end
      S_ADD: begin
        strb_d.busy    = 1'b1;
        strb_d.c_out   = 1'b1;
        strb_d.alu_add = 1'b1;
        strb_d.z_in    = 1'b1;
      end
      S_WB: begin
        strb_d.busy    = 1'b1;
        strb_d.zlo_out = 1'b1;
        strb_d.pc_in   = con_q;
      end
      S_FIN:   strb_d.done = 1'b1;
      default: strb_d = '0;
    endcase

    taken_d      = taken_q;
    taken_cnt_d  = taken_cnt_q;
    ntaken_cnt_d = ntaken_cnt_q;
    // Result of the write-back cycle is committed on the WB->FIN edge.
    if (state_q == S_WB) begin
      taken_d = strb_q.pc_in;
      if (strb_q.pc_in) taken_cnt_d = taken_cnt_q + CNT_W'(1);
      else              ntaken_cnt_d = ntaken_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q      <= S_IDLE;
      strb_q       <= '0;
      taken_q      <= 1'b0;
      taken_cnt_q  <= '0;
      ntaken_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      strb_q       <= strb_d;
      taken_q      <= taken_d;
      taken_cnt_q  <= taken_cnt_d;
      ntaken_cnt_q <= ntaken_cnt_d;
    end
  end

  assign busy       = strb_q.busy;
  assign gra        = strb_q.gra;
  assign r_out      = strb_q.r_out;
  assign con_en     = strb_q.con_en;
  assign pc_out     = strb_q.pc_out;
  assign y_in       = strb_q.y_in;
  assign c_out      = strb_q.c_out;
  assign alu_add    = strb_q.alu_add;
  assign z_in       = strb_q.z_in;
  assign zlo_out    = strb_q.zlo_out;
  assign pc_in      = strb_q.pc_in;
  assign done       = strb_q.done;
  assign taken      = taken_q;
  assign taken_cnt  = taken_cnt_q;
  assign ntaken_cnt = ntaken_cnt_q;

endmodule
